// File: rtl/muldiv_ctrl.sv
// Iterative radix-2 multiply/divide sequencer that owns the HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: trivial operands (zero multiply, divide by zero) skip the iteration phase.
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InsValid,
  input  logic [31:0]      Ins,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Mfdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]   acc_q, acc_d;   // partial product high half / partial remainder
  logic [WIDTH-1:0] shr_q, shr_d;   // multiplier shifting out / dividend in, quotient out
  logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand or divisor magnitude
  logic             div_q, div_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
  logic             done_q, done_d;

  logic [5:0]       funct;
  logic             r_form, hl_op, op_md, op_signed, op_div, sa, sb, early;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             unused_ins;

  assign funct      = Ins[5:0];
  assign unused_ins = ^Ins[25:6];
  assign r_form     = InsValid && (Ins[31:26] == 6'h00);
  assign hl_op      = r_form && (funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                               F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign op_md      = r_form && (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign op_signed  = (funct == F_MULT) || (funct == F_DIV);
  assign op_div     = (funct == F_DIV) || (funct == F_DIVU);
  assign sa         = op_signed && Rdata1[WIDTH-1];
  assign sb         = op_signed && Rdata2[WIDTH-1];
  assign mag_a      = sa ? -Rdata1 : Rdata1;
  assign mag_b      = sb ? -Rdata2 : Rdata2;

`ifdef MULDIV_EARLY_OUT_EN
  assign early = op_div ? (Rdata2 == '0) : ((Rdata1 == '0) || (Rdata2 == '0));
`else
  assign early = 1'b0;
`endif

  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign mul_sum  = acc_q + (shr_q[0] ? {1'b0, opa_q} : '0);
  assign div_sh   = {acc_q[WIDTH-1:0], shr_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opa_q};
  assign div_diff = div_sh - {1'b0, opa_q};
  assign prod     = {acc_q[WIDTH-1:0], shr_q};
  assign prod_fix = negq_q ? -prod : prod;
  // Divide by zero bypasses quotient sign fix-up; remainder fix-up restores the raw dividend.
  assign quo_fix  = dz_q ? '1 : (negq_q ? -shr_q : shr_q);
  assign rem_fix  = negr_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    shr_d   = shr_q;
    opa_d   = opa_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_md) begin
          div_d   = op_div;
          negq_d  = sa ^ sb;
          negr_d  = sa;
          dz_d    = op_div && (Rdata2 == '0);
          opa_d   = op_div ? mag_b : mag_a;
          acc_d   = (early && op_div) ? {1'b0, mag_a} : '0;
          shr_d   = early ? '0 : (op_div ? mag_a : mag_b);
          cnt_d   = '0;
          state_d = early ? S_FIX : S_RUN;
        end else if (hl_op && (funct == F_MTHI)) begin
          hi_d = Rdata1;
        end else if (hl_op && (funct == F_MTLO)) begin
          lo_d = Rdata1;
        end
      end
      S_RUN: begin
        if (div_q) begin
          acc_d = div_ge ? div_diff : div_sh;
          shr_d = {shr_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {1'b0, mul_sum[WIDTH:1]};
          shr_d = {mul_sum[0], shr_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      shr_q   <= '0;
      opa_q   <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      shr_q   <= shr_d;
      opa_q   <= opa_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign Busy   = (state_q != S_IDLE);
  assign Stall  = hl_op && Busy;
  assign Done   = done_q;
  assign Hi     = hi_q;
  assign Lo     = lo_q;
  assign Mfdata = (hl_op && (funct == F_MFHI)) ? hi_q :
                  (hl_op && (funct == F_MFLO)) ? lo_q : '0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl against an arithmetic reference model of HI/LO and busy timing.
module tb_muldiv_ctrl;
  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = W + 1;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          InsValid = 1'b0;
  logic [31:0]   Ins = '0;
  logic [W-1:0]  Rdata1 = '0, Rdata2 = '0;
  logic          Busy, Stall, Done;
  logic [W-1:0]  Hi, Lo, Mfdata;

  muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .InsValid(InsValid), .Ins(Ins),
    .Rdata1(Rdata1), .Rdata2(Rdata2), .Busy(Busy), .Stall(Stall),
    .Done(Done), .Hi(Hi), .Lo(Lo), .Mfdata(Mfdata)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  bit chk_en = 0;

  // Reference model: architectural HI/LO, cycles of Busy remaining, pending result.
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           m_left = 0;
  bit           m_done = 0;

  function automatic bit is_hl(input logic v, input logic [31:0] ins);
    return v && (ins[31:26] == 6'h00) &&
           (ins[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  function automatic logic [31:0] rins(input logic [5:0] f);
    return {6'h00, 20'h0, f};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [5:0]  f;
    logic [63:0] p;
    longint      sa, sb;
    bit          early;
    f = Ins[5:0];
    if (!RST) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1;
        end
      end else if (is_hl(InsValid, Ins)) begin
        early = 0;
        case (f)
          6'h11: m_hi = Rdata1;
          6'h13: m_lo = Rdata1;
          6'h18, 6'h19: begin
            if (f == 6'h18) p = longint'($signed(Rdata1)) * longint'($signed(Rdata2));
            else            p = {32'h0, Rdata1} * {32'h0, Rdata2};
            {p_hi, p_lo} = p;
            early = (Rdata1 == 0) || (Rdata2 == 0);
          end
          6'h1A, 6'h1B: begin
            early = (Rdata2 == 0);
            if (Rdata2 == 0) begin
              p_lo = '1; p_hi = Rdata1;
            end else if (f == 6'h1A) begin
              sa = longint'($signed(Rdata1)); sb = longint'($signed(Rdata2));
              p_lo = W'(sa / sb); p_hi = W'(sa % sb);
            end else begin
              p_lo = Rdata1 / Rdata2; p_hi = Rdata1 % Rdata2;
            end
          end
          default: ;
        endcase
        if (f inside {6'h18, 6'h19, 6'h1A, 6'h1B}) begin
`ifdef MULDIV_EARLY_OUT_EN
          m_left = early ? 1 : W + 1;
`else
          m_left = W + 1;
`endif
        end
      end
    end
  endtask

  always @(negedge CLK) begin
    logic [W-1:0] exp_mf;
    bit hl;
    if (chk_en) begin
      hl = is_hl(InsValid, Ins);
      exp_mf = '0;
      if (hl && Ins[5:0] == 6'h10) exp_mf = m_hi;
      if (hl && Ins[5:0] == 6'h12) exp_mf = m_lo;
      chk("busy",   64'(Busy),   64'(m_left > 0));
      chk("stall",  64'(Stall),  64'(hl && (m_left > 0)));
      chk("done",   64'(Done),   64'(m_done));
      chk("hi",     64'(Hi),     64'(m_hi));
      chk("lo",     64'(Lo),     64'(m_lo));
      chk("mfdata", 64'(Mfdata), 64'(exp_mf));
    end
  end

  task automatic drive(input logic r, input logic v, input logic [31:0] ins,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    RST = r; InsValid = v; Ins = ins; Rdata1 = a; Rdata2 = b;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  // Issue one op, then idle until Busy falls; n = cycles Busy was seen high.
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int n);
    drive(1, 1, rins(f), a, b);
    tick();
    drive(1, 0, rins(6'h18), $urandom, $urandom);
    n = 0;
    while (Busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic gen_ins(output logic v, output logic [31:0] ins);
    logic [5:0] fl [8] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
    int r;
    r = $urandom_range(0, 99);
    v = ($urandom_range(0, 19) != 0);
    if (r < 55)      ins = {6'h00, 20'($urandom), fl[$urandom_range(0, 7)]};
    else if (r < 75) ins = {6'h00, 20'($urandom), ($urandom_range(0, 1) != 0) ? 6'h20 : 6'h14};
    else             ins = {6'($urandom_range(1, 63)), 20'($urandom), fl[$urandom_range(0, 7)]};
  endtask

  initial begin
    int n;
    logic v;
    logic [31:0] ins;

    drive(0, 0, '0, '0, '0);
    tick();
    chk_en = 1;
    tick();
    drive(1, 0, '0, '0, '0);
    tick();
    chk("rst_hi", 64'(Hi), 64'h0);
    chk("rst_lo", 64'(Lo), 64'h0);
    chk("rst_busy", 64'(Busy), 64'h0);
    chk("rst_done", 64'(Done), 64'h0);

    run_op(6'h18, 32'd7, 32'hFFFF_FFFD, n);
    chk("mult_busy_cycles", 64'(n), 64'd33);
    chk("mult_done", 64'(Done), 64'h1);
    chk("mult_hi", 64'(Hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(Lo), 64'hFFFF_FFEB);
    chk("model_mult", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    tick();
    chk("mult_done_pulse", 64'(Done), 64'h0);

    run_op(6'h1B, 32'd100, 32'd7, n);
    chk("divu_lo", 64'(Lo), 64'd14);
    chk("divu_hi", 64'(Hi), 64'd2);
    chk("model_divu", {m_hi, m_lo}, {32'd2, 32'd14});

    run_op(6'h1A, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_neg_lo", 64'(Lo), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(Hi), 64'hFFFF_FFFF);
    chk("model_div_neg", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("div_ovf_lo", 64'(Lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(Hi), 64'h0);

    run_op(6'h1A, 32'd5, 32'd0, n);
    chk("div0_busy_cycles", 64'(n), 64'(DZ_LAT));
    chk("div0_lo", 64'(Lo), 64'hFFFF_FFFF);
    chk("div0_hi", 64'(Hi), 64'd5);
    chk("model_div0", {m_hi, m_lo}, {32'd5, 32'hFFFF_FFFF});

    run_op(6'h1A, 32'hFFFF_FFFB, 32'd0, n);
    chk("div0_neg_hi", 64'(Hi), 64'hFFFF_FFFB);
    chk("div0_neg_lo", 64'(Lo), 64'hFFFF_FFFF);

    // MFLO arriving three cycles into a multiply waits and then reads the new LO.
    drive(1, 1, rins(6'h19), 32'h0001_0000, 32'h0003_0003);
    tick();
    drive(1, 0, '0, '0, '0);
    tick();
    tick();
    drive(1, 1, rins(6'h12), '0, '0);
    #1;
    chk("mflo_stalled", 64'(Stall), 64'h1);
    n = 0;
    while (Stall && n < 100) begin
      tick();
      n++;
    end
    chk("mflo_released", 64'(Stall), 64'h0);
    chk("mflo_data", 64'(Mfdata), 64'h0003_0000);
    chk("mflo_hi", 64'(Hi), 64'h3);
    tick();

    drive(1, 1, rins(6'h11), 32'h1234, '0);
    #1;
    chk("mthi_nostall", 64'(Stall), 64'h0);
    tick();
    drive(1, 0, '0, '0, '0);
    chk("mthi_hi", 64'(Hi), 64'h1234);

    // Reset in the middle of an iteration abandons the result.
    drive(1, 1, rins(6'h18), 32'd9, 32'd9);
    tick();
    drive(1, 0, '0, '0, '0);
    for (int i = 0; i < 10; i++) tick();
    drive(0, 0, '0, '0, '0);
    tick();
    drive(1, 0, '0, '0, '0);
    chk("midrst_hi", 64'(Hi), 64'h0);
    chk("midrst_lo", 64'(Lo), 64'h0);
    chk("midrst_busy", 64'(Busy), 64'h0);
    for (int i = 0; i < 40; i++) tick();
    chk("midrst_lo_after", 64'(Lo), 64'h0);

    for (int i = 0; i < 3000; i++) begin
      if (!(RST && is_hl(InsValid, Ins) && m_left > 0)) begin
        gen_ins(v, ins);
        drive(1, v, ins, rnd_opnd(), rnd_opnd());
      end
      RST = ($urandom_range(0, 299) != 0);
      if (is_hl(InsValid, Ins) && m_left > 0 && $urandom_range(0, 3) == 0) begin
        Rdata1 = $urandom;
        Rdata2 = $urandom;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative multiply/divide sequencer for the MIPS core. It owns the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the instruction currently in ID. Operands come from the register-file read ports (Rdata1=rs, Rdata2=rt). The block runs a radix-2 shift-add/subtract datapath over several cycles and stalls the pipeline when a HI/LO-class instruction arrives while busy.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  synchronous, active-low reset; RST=0 at a rising edge resets the block.
InsValid  input  1  Ins holds a real instruction this cycle.
Ins  input  32  instruction word; opcode Ins[31:26], funct Ins[5:0].
Rdata1  input  WIDTH  rs value (dividend / multiplicand / MTxx source).
Rdata2  input  WIDTH  rt value (divisor / multiplier).
Busy  output  1  operation in flight (state != IDLE).
Stall  output  1  hold the front end this cycle.
Done  output  1  one-cycle pulse on the cycle after HI/LO are written by MULT/DIV.
Hi  output  WIDTH  current HI register.
Lo  output  WIDTH  current LO register.
Mfdata  output  WIDTH  MFHI→Hi, MFLO→Lo, otherwise 0.

Behaviour:
- Decode uses the common_param.vh codes:
  - R_FORM opcode 6'h00.
  - MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13.
  - MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B.
  - "hl-op" means InsValid & R_FORM & funct in this set.
- Reset (RST=0 at an edge): state=IDLE, Hi=Lo=0, counter=0, Done=0. Any in-flight operation is abandoned with no HI/LO write.
- States: IDLE, RUN, FIX.
- IDLE:
  - On an edge with an hl-op of MULT/MULTU/DIV/DIVU, latch the operand magnitudes, a signed flag, the result-sign bits and the op kind; set counter=0; go to RUN.
  - MTHI/MTLO write Hi/Lo from Rdata1 at that edge and stay in IDLE.
  - MFHI/MFLO have no state effect.
- RUN:
  - Performs one iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Counter increments each cycle; after WIDTH iterations (counter==WIDTH-1 at the edge) go to FIX.
- FIX:
  - Applies sign correction and writes Hi/Lo, then returns to IDLE.
  - Done=1 during the following cycle.
- Latency: accept edge N → Hi/Lo valid after edge N+WIDTH+1 (34 edges for WIDTH=32).
- Multiply: 2·WIDTH-bit product {Hi,Lo}.
  - MULT is signed (magnitudes, product negated if operand signs differ).
  - MULTU is unsigned.
- Divide: Lo=quotient, Hi=remainder.
  - DIV truncates toward zero; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
- Divide by zero (rt=0): Lo=all ones, Hi=Rdata1 as latched. Applies to both DIV and DIVU.
- Stall = hl-op & Busy, combinational:
  - A new MULT/DIV, MTxx or MFxx arriving while busy stalls until the cycle after FIX.
  - The stalled instruction must be re-presented; it is accepted when Busy=0.
- Non-hl-op instructions never stall and never affect state.
- MFHI/MFLO in the same cycle Busy falls read the updated values (Hi/Lo are registered, written at the FIX edge).
- Operands are latched only at the accept edge; later changes on Rdata1/Rdata2 are ignored.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined:
  - At accept, if the op is a multiply with either operand 0, or a divide with rt=0, skip RUN and go IDLE→FIX.
  - Results are identical; latency is 2 edges and Busy is high for 1 cycle.
- Undefined: every MULT/DIV takes the fixed WIDTH+2 cycle path regardless of operand values.

Test Plan:
- RST=0 for 2 edges, then RST=1 → Hi=Lo=0, Busy=0, Stall=0, Done=0.
- MULT rs=7, rt=0xFFFFFFFD → Busy high 33 cycles; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Done pulses once.
- DIVU 100/7 → Lo=14, Hi=2.
- DIV 0xFFFFFFF9/2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV 5/0 → Lo=0xFFFFFFFF, Hi=5; with MULDIV_EARLY_OUT_EN, Busy is high 1 cycle only.
- MFLO presented 3 cycles after a MULT issue → Stall=1 until Busy falls, then Mfdata equals the new Lo.
- MTHI 0x1234 while idle → Hi=0x1234 next cycle, no stall.
- RST=0 at RUN cycle 10 → IDLE, Hi=Lo=0, no Done pulse.
